// File: rtl/systolic_result_drain.sv
// Result drain for a 3x3 systolic array: snapshots the accumulators when done rises,
// streams them row-major over valid/ready, then pulses a registered clear into the array.
module systolic_result_drain #(
    parameter int N_RES  = 9,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    done,
    input  logic [N_RES*DATA_W-1:0] results,
    input  logic                    m_ready,
    output logic                    m_valid,
    output logic [DATA_W-1:0]       m_data,
    output logic [IDX_W-1:0]        m_index,
    output logic                    m_last,
    output logic                    array_clr,
    output logic                    busy,
    output logic [7:0]              frame_count
);

    typedef enum logic [1:0] {IDLE, STREAM, CLEAR, WAIT_LOW} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RES - 1);

    state_t                          state_q, state_d;
    logic [N_RES-1:0][DATA_W-1:0]    buf_q, buf_d;
    logic                            m_valid_q, m_valid_d;
    logic [IDX_W-1:0]                m_index_q, m_index_d;
    logic                            m_last_q, m_last_d;
    logic                            array_clr_q, array_clr_d;
    logic                            busy_q, busy_d;
    logic [7:0]                      frame_count_q, frame_count_d;

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        m_valid_d     = m_valid_q;
        m_index_d     = m_index_q;
        m_last_d      = m_last_q;
        array_clr_d   = 1'b0;
        frame_count_d = frame_count_q;
        case (state_q)
            IDLE: begin
                if (done) begin
                    buf_d     = results;
                    m_index_d = '0;
                    m_valid_d = 1'b1;
                    m_last_d  = (LAST_IDX == '0);
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (m_ready) begin
                    if (m_last_q) begin
                        m_valid_d     = 1'b0;
                        m_index_d     = '0;
                        m_last_d      = 1'b0;
                        frame_count_d = frame_count_q + 8'd1;
                        array_clr_d   = 1'b1;
                        state_d       = CLEAR;
                    end else begin
                        m_index_d = m_index_q + 1'b1;
                        m_last_d  = (m_index_d == LAST_IDX);
                    end
                end
            end
            CLEAR: state_d = WAIT_LOW;
            // Hold off re-capture until the array has actually dropped done.
            WAIT_LOW: if (!done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            buf_q         <= '0;
            m_valid_q     <= 1'b0;
            m_index_q     <= '0;
            m_last_q      <= 1'b0;
            array_clr_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            m_valid_q     <= m_valid_d;
            m_index_q     <= m_index_d;
            m_last_q      <= m_last_d;
            array_clr_q   <= array_clr_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = buf_q[m_index_q];
    assign m_index     = m_index_q;
    assign m_last      = m_last_q;
    assign array_clr   = array_clr_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: drain, backpressure, capture isolation,
// stale done, async reset mid-frame and frame counter wrap.
module tb_systolic_result_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic         done;
    logic [287:0] results;
    logic         m_ready;
    logic         m_valid;
    logic [31:0]  m_data;
    logic [3:0]   m_index;
    logic         m_last;
    logic         array_clr;
    logic         busy;
    logic [7:0]   frame_count;

    int n_chk  = 0;
    int n_fail = 0;

    systolic_result_drain #(.N_RES(9), .DATA_W(32), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .done(done), .results(results), .m_ready(m_ready),
        .m_valid(m_valid), .m_data(m_data), .m_index(m_index), .m_last(m_last),
        .array_clr(array_clr), .busy(busy), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] base);
        for (int k = 0; k < 9; k++) results[k*32 +: 32] = base + 32'(k);
    endtask

    int exp_k;
    int c;

    initial begin
        rst = 1'b1; done = 1'b0; m_ready = 1'b0; results = '0;
        #12;
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", m_data, 0);
        chk("rst_index", 32'(m_index), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_clr", 32'(array_clr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frames", 32'(frame_count), 0);
        step;
        rst = 1'b0;
        step;

        // Basic drain
        load(32'h100); m_ready = 1'b1; done = 1'b1;
        step;
        chk("basic_busy", 32'(busy), 1);
        for (int k = 0; k < 9; k++) begin
            chk("basic_valid", 32'(m_valid), 1);
            chk("basic_data", m_data, 32'h100 + 32'(k));
            chk("basic_index", 32'(m_index), 32'(k));
            chk("basic_last", 32'(m_last), (k == 8) ? 1 : 0);
            step;
        end
        chk("basic_end_valid", 32'(m_valid), 0);
        chk("basic_clr", 32'(array_clr), 1);
        chk("basic_frames", 32'(frame_count), 1);
        step;
        chk("basic_clr_off", 32'(array_clr), 0);
        chk("basic_wait_busy", 32'(busy), 1);
        done = 1'b0;
        step;
        chk("basic_idle", 32'(busy), 0);

        // Backpressure + input change after capture
        load(32'h200); done = 1'b1;
        step;
        exp_k = 0; c = 0;
        while (exp_k < 9 && c < 100) begin
            chk("bp_valid", 32'(m_valid), 1);
            chk("bp_index", 32'(m_index), 32'(exp_k));
            chk("bp_data", m_data, 32'h200 + 32'(exp_k));
            chk("bp_last", 32'(m_last), (exp_k == 8) ? 1 : 0);
            m_ready = ((c % 3) == 0);
            if (c == 2) results = {9{32'hDEADBEEF}};
            step;
            if (m_ready) exp_k++;
            c++;
        end
        chk("bp_words_done", 32'(exp_k), 9);
        chk("bp_end_valid", 32'(m_valid), 0);
        chk("bp_clr", 32'(array_clr), 1);
        chk("bp_frames", 32'(frame_count), 2);

        // Stale done held for 20 cycles after the clear
        m_ready = 1'b1;
        step;
        chk("stale_clr_off", 32'(array_clr), 0);
        for (int i = 0; i < 20; i++) begin
            chk("stale_valid", 32'(m_valid), 0);
            chk("stale_busy", 32'(busy), 1);
            step;
        end
        done = 1'b0;
        step;
        chk("stale_idle", 32'(busy), 0);
        chk("stale_valid_idle", 32'(m_valid), 0);

        // Async reset after word 4 has transferred
        load(32'h300); done = 1'b1;
        step;
        repeat (5) step;
        chk("mid_index", 32'(m_index), 5);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_clr", 32'(array_clr), 0);
        chk("mid_rst_frames", 32'(frame_count), 0);
        chk("mid_rst_index", 32'(m_index), 0);
        @(negedge clk);
        rst = 1'b0;
        step;
        chk("fresh_valid", 32'(m_valid), 1);
        chk("fresh_index", 32'(m_index), 0);
        chk("fresh_data", m_data, 32'h300);
        repeat (9) step;
        chk("fresh_frames", 32'(frame_count), 1);
        done = 1'b0;
        step; step;
        chk("fresh_idle", 32'(busy), 0);

        // Frame counter wrap
        rst = 1'b1;
        #1 rst = 1'b0;
        load(32'h400);
        for (int f = 1; f <= 256; f++) begin
            done = 1'b1;
            step;
            repeat (9) step;
            if (f == 255) chk("wrap_255", 32'(frame_count), 255);
            if (f == 256) chk("wrap_0", 32'(frame_count), 0);
            done = 1'b0;
            step; step;
        end
        chk("wrap_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Consumer side of the 3x3 systolic array's result interface.
- Once the array raises done, the block snapshots all nine 32-bit accumulator results and streams them row-major over a valid/ready port.
- It then pulses a registered clear into the array and re-arms for the next matrix product.
- Sits between the systolic array and the downstream result sink.

Parameters:
- N_RES, 9, number of result words per frame (3x3 array).
- DATA_W, 32, width of each result word.
- IDX_W, 4, width of result index output (must satisfy 2**IDX_W >= N_RES).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- done  input  1  array completion flag (level; stays high until the array is reset).
- results  input  N_RES*DATA_W  packed array results; word k at bits [k*DATA_W +: DATA_W], k=0..8 row-major.
- m_ready  input  1  downstream ready.
- m_valid  output  1  result word valid.
- m_data  output  DATA_W  current result word.
- m_index  output  IDX_W  index k of m_data.
- m_last  output  1  high with the word where m_index == N_RES-1.
- array_clr  output  1  registered one-cycle clear pulse to the array's reset input.
- busy  output  1  high in any state other than IDLE.
- frame_count  output  8  count of fully drained frames; wraps 255 -> 0.

Behaviour:
- Reset (async): state=IDLE; m_valid=0, m_data=0, m_index=0, m_last=0, array_clr=0, busy=0, frame_count=0; capture buffer cleared.
- States: IDLE, STREAM, CLEAR, WAIT_LOW.
- IDLE:
  - When done==1 at a clock edge, load all N_RES words of results into the internal buffer on that same edge.
  - Set m_index=0 and m_valid=1, then go to STREAM.
  - Latency is one cycle: m_valid is high in the cycle after done is first sampled high.
- STREAM:
  - m_data is buffer[m_index] and is driven from the buffer only; changes on results are ignored after capture.
  - Transfer occurs on an edge where m_valid && m_ready.
  - While m_valid && !m_ready, m_data, m_index and m_last hold stable.
  - On a transfer with m_index < N_RES-1: m_index increments and m_valid stays high, so back-to-back words go out at one per cycle when m_ready is held high.
  - On a transfer with m_index == N_RES-1 (m_last=1):
    - m_valid drops to 0 and m_index returns to 0.
    - frame_count increments, mod 256.
    - array_clr goes to 1 and state goes to CLEAR.
- CLEAR:
  - array_clr is high for exactly one cycle and comes from a flop (glitch-free for the array's async reset).
  - Next edge: array_clr=0, go to WAIT_LOW.
- WAIT_LOW:
  - Remain until done==0 is sampled, then go to IDLE.
  - This prevents a second capture of a stale done.
  - No capture is possible in WAIT_LOW even if done is high.
- busy: 1 in STREAM, CLEAR and WAIT_LOW; 0 in IDLE.
- m_valid is never high outside STREAM.
- Minimum frame time with m_ready=1: 1 capture edge + 9 transfers + CLEAR + at least one WAIT_LOW cycle.
- Reset mid-STREAM:
  - All outputs return to reset values immediately (async).
  - The partially sent frame is discarded, frame_count=0, and no array_clr is issued.
  - After rst deasserts, if done is still high the block captures again from IDLE. The system reset also resets the array, so done is normally low.
- Arithmetic: the frame_count wrap is modular.
- Results are passed through unmodified; no sign handling or truncation.

Test Plan:
- Basic drain:
  - Stimulus: results word k = 32'h100+k; raise done; m_ready=1.
  - Response: m_valid one cycle after done is sampled; words 0x100..0x108 on 9 consecutive cycles with m_index 0..8; m_last only on 0x108; array_clr single-cycle pulse next; frame_count=1.
- Backpressure:
  - Stimulus: m_ready toggles 1,0,0,1,... during a frame.
  - Response: m_data and m_index are held unchanged on every m_ready=0 cycle; all 9 words are delivered once each, in order, with no duplicates.
- Input change after capture:
  - Stimulus: change results to all 32'hDEADBEEF two cycles after capture.
  - Response: the stream still carries the originally captured values.
- Stale done:
  - Stimulus: hold done=1 for 20 cycles after array_clr before dropping it.
  - Response: block stays in WAIT_LOW with busy=1 and no second m_valid; returns to IDLE (busy=0) one edge after done=0.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously after word 4 is transferred.
  - Response: m_valid, busy and array_clr go 0 without waiting for a clock edge; frame_count=0; a fresh frame afterward starts at m_index=0.
- Counter wrap:
  - Stimulus: run 256 back-to-back frames.
  - Response: frame_count reads 255 after frame 255 and 0 after frame 256.
